// File: rtl/display_timing_rx_pkg.sv
// rtl/display_timing_rx_pkg.sv - shared FSM state and timing-measurement types for the display timing receiver
package display_timing_rx_pkg;

    // Measurement fields are held at a fixed width; the top narrows them to CORDW (CORDW <= MEAS_W).
    localparam int MEAS_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    typedef struct packed {
        logic [MEAS_W-1:0] h_res;
        logic [MEAS_W-1:0] v_res;
        logic [MEAS_W-1:0] h_total;
        logic [MEAS_W-1:0] v_total;
    } timing_t;

endpackage

// File: rtl/display_timing_rx_if.sv
// rtl/display_timing_rx_if.sv - raw video sync/enable bundle from the source
interface display_timing_rx_if;
    logic hsync_in;
    logic vsync_in;
    logic de_in;

    modport master (output hsync_in, output vsync_in, output de_in);
    modport slave  (input  hsync_in, input  vsync_in, input  de_in);
endinterface

// File: rtl/display_timing_rx_sync_edge.sv
// rtl/display_timing_rx_sync_edge.sv - two-stage register with polarity normalisation; lvl_o/prev_o feed edge detection
module sync_edge #(
    parameter bit POL = 1'b1
) (
    input  logic clk_pix,
    input  logic rst_pix,
    input  logic sig_i,
    output logic lvl_o,
    output logic prev_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= (sig_i == POL);
            s2_q <= s1_q;
        end
    end

    assign lvl_o  = s1_q;
    assign prev_o = s2_q;

endmodule

// File: rtl/display_timing_rx.sv
// rtl/display_timing_rx.sv - recovers sx/sy/line/frame from sync+de and locks onto stable measured timing
module display_timing_rx
    import display_timing_rx_pkg::*;
#(
    parameter int CORDW     = 16,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1,
    parameter int TIMEOUT_W = 24
) (
    input  logic               clk_pix,
    input  logic               rst_pix,
    display_timing_rx_if.slave vid,
    output logic               de,
    output logic               frame,
    output logic               line,
    output logic [CORDW-1:0]   sx,
    output logic [CORDW-1:0]   sy,
    output logic [CORDW-1:0]   h_res,
    output logic [CORDW-1:0]   v_res,
    output logic [CORDW-1:0]   h_total,
    output logic [CORDW-1:0]   v_total,
    output logic               locked
);

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (&v) ? v : v + CORDW'(1);
    endfunction

    logic hs_lvl, hs_prev, vs_lvl, vs_prev, de_lvl, de_prev;
    logic hs_rise, vs_rise, de_rise, de_fall;

    sync_edge #(.POL(H_POL)) u_hs (
        .clk_pix (clk_pix), .rst_pix (rst_pix), .sig_i (vid.hsync_in),
        .lvl_o   (hs_lvl),  .prev_o  (hs_prev)
    );
    sync_edge #(.POL(V_POL)) u_vs (
        .clk_pix (clk_pix), .rst_pix (rst_pix), .sig_i (vid.vsync_in),
        .lvl_o   (vs_lvl),  .prev_o  (vs_prev)
    );
    sync_edge #(.POL(1'b1)) u_de (
        .clk_pix (clk_pix), .rst_pix (rst_pix), .sig_i (vid.de_in),
        .lvl_o   (de_lvl),  .prev_o  (de_prev)
    );

    assign hs_rise = hs_lvl & ~hs_prev;
    assign vs_rise = vs_lvl & ~vs_prev;
    assign de_rise = de_lvl & ~de_prev;
    assign de_fall = ~de_lvl & de_prev;

    state_e               state_q, state_d;
    timing_t              cand_q, cand_d, meas_q, meas_d, cand_new;
    logic                 cand_valid_q, cand_valid_d;
    logic [CORDW-1:0]     h_cnt_q, h_cnt_d, h_per_q, h_per_d;
    logic [CORDW-1:0]     run_cnt_q, run_cnt_d, last_run_q, last_run_d;
    logic [CORDW-1:0]     l_cnt_q, l_cnt_d, a_cnt_q, a_cnt_d;
    logic [CORDW-1:0]     sx_q, sx_d, sy_q, sy_d;
    logic                 frame_pend_q, frame_pend_d;
    logic                 de_q, de_d, line_q, line_d, frame_q, frame_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 timeout, run_bad, first_line;

    // Snapshot of the frame that just completed, taken at the vsync edge.
    always_comb begin
        cand_new         = '0;
        cand_new.h_res   = MEAS_W'(last_run_q);
        cand_new.v_res   = MEAS_W'(a_cnt_q);
        cand_new.h_total = MEAS_W'(h_per_q);
        cand_new.v_total = MEAS_W'(l_cnt_q);
    end

    assign timeout = (&wd_q) & ~vs_rise;
    assign run_bad = de_fall & (MEAS_W'(run_cnt_q) != meas_q.h_res);

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (vs_rise) state_d = MEASURE;
                MEASURE: if (vs_rise && cand_valid_q && (cand_new == cand_q)) state_d = LOCKED;
                LOCKED:  if (run_bad || (vs_rise && (cand_new != meas_q))) state_d = MEASURE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    // Candidate/measurement bookkeeping; a lock loss from a bad run forces two fresh frames.
    always_comb begin
        cand_d       = cand_q;
        cand_valid_d = cand_valid_q;
        meas_d       = meas_q;
        case (state_q)
            IDLE: cand_valid_d = 1'b0;
            MEASURE: begin
                if (vs_rise) begin
                    if (state_d == LOCKED) begin
                        meas_d = cand_new;
                    end else begin
                        cand_d       = cand_new;
                        cand_valid_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (run_bad) begin
                    cand_valid_d = 1'b0;
                end else if (vs_rise && (state_d == MEASURE)) begin
                    cand_d       = cand_new;
                    cand_valid_d = 1'b1;
                end
            end
            default: cand_valid_d = 1'b0;
        endcase
    end

    always_comb begin
        h_cnt_d    = hs_rise ? CORDW'(1) : sat_inc(h_cnt_q);
        h_per_d    = hs_rise ? h_cnt_q : h_per_q;
        run_cnt_d  = run_cnt_q;
        if (de_lvl) run_cnt_d = de_rise ? CORDW'(1) : sat_inc(run_cnt_q);
        last_run_d = de_fall ? run_cnt_q : last_run_q;

        // The vsync edge clears the frame counters before this cycle's hsync/de edges are counted.
        if (vs_rise) begin
            l_cnt_d = hs_rise ? CORDW'(1) : '0;
            a_cnt_d = de_rise ? CORDW'(1) : '0;
        end else begin
            l_cnt_d = hs_rise ? sat_inc(l_cnt_q) : l_cnt_q;
            a_cnt_d = de_rise ? sat_inc(a_cnt_q) : a_cnt_q;
        end

        first_line   = de_rise & (vs_rise | frame_pend_q);
        frame_pend_d = (vs_rise | frame_pend_q) & ~de_rise;
        wd_d         = vs_rise ? '0 : ((&wd_q) ? wd_q : wd_q + TIMEOUT_W'(1));

        de_d    = de_lvl;
        line_d  = de_rise;
        frame_d = first_line;
        sx_d    = sx_q;
        if (de_lvl) sx_d = de_rise ? '0 : sat_inc(sx_q);
        sy_d    = sy_q;
        if (de_rise) sy_d = first_line ? '0 : sat_inc(sy_q);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            cand_q       <= '0;
            meas_q       <= '0;
            cand_valid_q <= 1'b0;
            h_cnt_q      <= '0;
            h_per_q      <= '0;
            run_cnt_q    <= '0;
            last_run_q   <= '0;
            l_cnt_q      <= '0;
            a_cnt_q      <= '0;
            frame_pend_q <= 1'b0;
            wd_q         <= '0;
            de_q         <= 1'b0;
            line_q       <= 1'b0;
            frame_q      <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
        end else begin
            cand_q       <= cand_d;
            meas_q       <= meas_d;
            cand_valid_q <= cand_valid_d;
            h_cnt_q      <= h_cnt_d;
            h_per_q      <= h_per_d;
            run_cnt_q    <= run_cnt_d;
            last_run_q   <= last_run_d;
            l_cnt_q      <= l_cnt_d;
            a_cnt_q      <= a_cnt_d;
            frame_pend_q <= frame_pend_d;
            wd_q         <= wd_d;
            de_q         <= de_d;
            line_q       <= line_d;
            frame_q      <= frame_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
        end
    end

    assign de      = de_q;
    assign line    = line_q;
    assign frame   = frame_q;
    assign sx      = sx_q;
    assign sy      = sy_q;
    assign h_res   = CORDW'(meas_q.h_res);
    assign v_res   = CORDW'(meas_q.v_res);
    assign h_total = CORDW'(meas_q.h_total);
    assign v_total = CORDW'(meas_q.v_total);

endmodule

// File: doc/display_timing_rx.md
DISPLAY_TIMING_RX -- requirements
Module: display_timing_rx

Interface
REQ-001 Parameter CORDW, default 16, width of coordinate and measurement outputs (bits).
REQ-002 Parameter H_POL, default 1, hsync_in active polarity (0: neg, 1: pos).
REQ-003 Parameter V_POL, default 1, vsync_in active polarity (0: neg, 1: pos).
REQ-004 Parameter TIMEOUT_W, default 24, width of the no-vsync watchdog counter.
REQ-005 clk_pix  input  1  pixel clock; the block SHALL use one clock.
REQ-006 rst_pix  input  1  reset; synchronous, active-high.
REQ-007 hsync_in  input  1  horizontal sync from the source.
REQ-008 vsync_in  input  1  vertical sync from the source.
REQ-009 de_in  input  1  data enable from the source.
REQ-010 de  output  1  de_in delayed to match sx/sy.
REQ-011 frame  output  1  one-cycle pulse at the first active pixel of a frame.
REQ-012 line  output  1  one-cycle pulse at the first active pixel of each line.
REQ-013 sx, sy  output  CORDW each  recovered unsigned active-area position.
REQ-014 h_res, v_res, h_total, v_total  output  CORDW each  measured timing of the last locked frame.
REQ-015 locked  output  1  high while the measured timing is stable.

Function
REQ-016 Inputs SHALL pass through one register stage; a second register stage provides edge detection; de/sx/sy/line/frame SHALL lag the input pixel by exactly 2 cycles.
REQ-017 A sync active edge is a transition to the active level set by H_POL/V_POL; a de rising edge is a 0->1 transition of registered de.
REQ-018 sx SHALL be 0 on the first de cycle of a run and increment by 1 on each further de cycle; during blanking it SHALL hold its value.
REQ-019 sy SHALL be 0 on the first de run after a vsync active edge and increment by 1 at each subsequent de rising edge; during blanking it SHALL hold its value.
REQ-020 line SHALL pulse with every de rising edge; frame SHALL pulse only when that edge is the first after a vsync active edge.
REQ-021 Counters: h_cnt counts cycles between hsync active edges; run_cnt counts de cycles per run; l_cnt counts hsync edges per frame; a_cnt counts de runs per frame; all SHALL saturate at all-ones and never wrap.
REQ-022 At each vsync active edge, the completed frame's values (last run_cnt, a_cnt, last h_cnt period, l_cnt) SHALL become the candidate, and the frame counters SHALL clear.
REQ-023 FSM states: IDLE, MEASURE, LOCKED.
REQ-024 IDLE -> MEASURE on the first vsync active edge; that partial frame is discarded.
REQ-025 MEASURE -> LOCKED when a completed frame's candidate equals the previous candidate in all four fields; h_res/v_res/h_total/v_total SHALL update on the same cycle locked rises.
REQ-026 In MEASURE, a completed frame whose candidate differs SHALL replace the previous candidate and remain in MEASURE.
REQ-027 LOCKED -> MEASURE, locked low on the next cycle, when any de run length differs from h_res or a completed frame differs from the stored values; measurement outputs SHALL hold their last values.
REQ-028 From any state, no vsync active edge within 2^TIMEOUT_W cycles SHALL return to IDLE with locked low.
REQ-029 A vsync edge and a de rising edge in the same cycle: the vsync edge is processed first, so the de run becomes line 0 of the new frame.
REQ-030 A de run still in progress at a vsync edge SHALL continue counting into the new frame.

Reset
REQ-031 While rst_pix is high: state IDLE; de, frame, line, locked = 0; sx, sy, all measurements, all counters = 0; pipeline registers cleared.
REQ-032 Reset asserted mid-frame SHALL take effect on the next clock edge with no residual pulse, and lock SHALL require two full frames after release.

Structure
REQ-033 The FSM state enum and a timing-measurement struct (h_res, v_res, h_total, v_total) SHALL live in the shared display package.
REQ-034 One sub-module, sync_edge (register, polarity normalise, rising-edge pulse), SHALL be instantiated for hsync, vsync and de.

Verification
REQ-035 Drive the 24x18 source (H 24/3/4/4, V 18/3/2/7, positive) -> locked rises at the start of the 3rd vsync edge; h_res=24, v_res=18, h_total=35, v_total=30.
REQ-036 Locked 24x18 stream -> frame pulse with sx=0, sy=0; line pulses 18 per frame; sx reaches 23 and sy reaches 17; de output equals de_in delayed 2 cycles.
REQ-037 Same timing with H_POL=0, V_POL=0 and inverted syncs -> identical measurements and lock point.
REQ-038 Locked, then one de run shortened to 20 -> locked low 1 cycle after the run ends; relock with the same values two frames after restoration.
REQ-039 Stop vsync with TIMEOUT_W=8 -> locked low and state IDLE after 256 cycles without an edge.
REQ-040 Assert rst_pix for 1 cycle mid-line while locked -> all outputs 0 on the next cycle; relock after two clean frames.
